// File: rtl/output_assembler_if.sv
// Handshake and data bus between the datapath/controller and the output assembler.
// The master drives transfer control and the nibble stream; the slave returns status and assembled data.
interface output_assembler_if #(
    parameter int NIB_W     = 4,
    parameter int MAIN_NIBS = 16,
    parameter int REGS_NIBS = 64
);
    localparam int MIDX_W = $clog2(MAIN_NIBS);
    localparam int IDX_W  = $clog2(REGS_NIBS);
    localparam int CNT_W  = $clog2(REGS_NIBS + 1);

    logic                         wStart;
    logic                         wSelecOrigin;
    logic [MIDX_W-1:0]            wSelecMain;
    logic [IDX_W-1:0]             wSelecRegs;
    logic [CNT_W-1:0]             wCount;
    logic [NIB_W-1:0]             r;
    logic                         rValid;
    logic                         rReady;
    logic                         wBusy;
    logic                         wDone;
    logic [MAIN_NIBS*NIB_W-1:0]   wData;
    logic [REGS_NIBS*NIB_W-1:0]   wDataRegs;

    modport master (
        output wStart, wSelecOrigin, wSelecMain, wSelecRegs, wCount, r, rValid,
        input  rReady, wBusy, wDone, wData, wDataRegs
    );

    modport slave (
        input  wStart, wSelecOrigin, wSelecMain, wSelecRegs, wCount, r, rValid,
        output rReady, wBusy, wDone, wData, wDataRegs
    );
endinterface

// File: rtl/output_assembler.sv
// Packs a stream of nibbles into the main word or the register bank from a start index with wrap.
// Optional feature: CLEAR_ON_START_EN clears the selected destination when a transfer is accepted.
module output_assembler #(
    parameter int NIB_W     = 4,
    parameter int MAIN_NIBS = 16,
    parameter int REGS_NIBS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output_assembler_if.slave bus
);
    localparam int MIDX_W = $clog2(MAIN_NIBS);
    localparam int IDX_W  = $clog2(REGS_NIBS);
    localparam int CNT_W  = $clog2(REGS_NIBS + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]                 state_r;
    logic [1:0]                 state_s;
    logic                       origin_r;
    logic [IDX_W-1:0]           idx_r;
    logic [IDX_W-1:0]           idx_nxt_s;
    logic [MIDX_W-1:0]          main_idx_inc_s;
    logic [CNT_W-1:0]           rem_r;
    logic [CNT_W-1:0]           count_sat_s;
    logic                       start_s;
    logic                       xfer_s;
    logic                       ready_r;
    logic                       busy_r;
    logic                       done_r;
    logic [MAIN_NIBS*NIB_W-1:0] data_r;
    logic [REGS_NIBS*NIB_W-1:0] regs_r;

    assign count_sat_s    = (bus.wCount > CNT_W'(REGS_NIBS)) ? CNT_W'(REGS_NIBS) : bus.wCount;
    assign start_s        = (state_r == ST_IDLE) && bus.wStart;
    assign xfer_s         = (state_r == ST_RUN) && ready_r && bus.rValid;
    assign main_idx_inc_s = idx_r[MIDX_W-1:0] + MIDX_W'(1);

    // Main word wraps at its own size; the bank wraps naturally at the index width.
    always_comb begin
        idx_nxt_s = idx_r;
        if (origin_r) begin
            idx_nxt_s = idx_r + IDX_W'(1);
        end else begin
            idx_nxt_s = IDX_W'(main_idx_inc_s);
        end
    end

    // Next-state decode of the transfer sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.wStart) begin
                    state_s = (count_sat_s == CNT_W'(0)) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (xfer_s && (rem_r == CNT_W'(1))) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State and status outputs, registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == ST_RUN);
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    // Transfer context: destination, write index and remaining nibble count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            origin_r <= 1'b0;
            idx_r    <= '0;
            rem_r    <= '0;
        end else if (start_s) begin
            origin_r <= bus.wSelecOrigin;
            idx_r    <= bus.wSelecOrigin ? bus.wSelecRegs : IDX_W'(bus.wSelecMain);
            rem_r    <= count_sat_s;
        end else if (xfer_s) begin
            idx_r <= idx_nxt_s;
            rem_r <= rem_r - CNT_W'(1);
        end else begin
            rem_r <= rem_r;
        end
    end

    // Destination storage; only the selected vector is ever touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            regs_r <= '0;
        end else if (xfer_s) begin
            if (origin_r) begin
                regs_r[idx_r*NIB_W +: NIB_W] <= bus.r;
            end else begin
                data_r[idx_r[MIDX_W-1:0]*NIB_W +: NIB_W] <= bus.r;
            end
        end
`ifdef CLEAR_ON_START_EN
        else if (start_s) begin
            if (bus.wSelecOrigin) begin
                regs_r <= '0;
            end else begin
                data_r <= '0;
            end
        end
`endif
        else begin
            data_r <= data_r;
        end
    end

    assign bus.rReady    = ready_r;
    assign bus.wBusy     = busy_r;
    assign bus.wDone     = done_r;
    assign bus.wData     = data_r;
    assign bus.wDataRegs = regs_r;
endmodule

// File: tb/tb_output_assembler.sv
// Randomized bench for output_assembler with a nibble-array reference model checked every cycle.
module tb_output_assembler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    output_assembler_if bus ();
    output_assembler dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int dut_xfers = 0;
    int done_pulses = 0;

    // Reference model: transfer phase (0 idle, 1 accepting, 2 completing) and plain nibble arrays.
    int m_mode = 0;
    int m_org = 0;
    int m_idx = 0;
    int m_rem = 0;
    logic [3:0] m_main [16];
    logic [3:0] m_bank [64];
    logic [3:0] feed_q [$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_main();
        logic [63:0] v;
        for (int i = 0; i < 16; i++) v[i*4 +: 4] = m_main[i];
        return v;
    endfunction

    function automatic logic [255:0] pack_bank();
        logic [255:0] v;
        for (int i = 0; i < 64; i++) v[i*4 +: 4] = m_bank[i];
        return v;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_org = 0; m_idx = 0; m_rem = 0;
        for (int i = 0; i < 16; i++) m_main[i] = 4'h0;
        for (int i = 0; i < 64; i++) m_bank[i] = 4'h0;
    endtask

    task automatic m_step();
        case (m_mode)
            0: if (bus.wStart) begin
                m_org = int'(bus.wSelecOrigin);
                m_idx = m_org ? int'(bus.wSelecRegs) : int'(bus.wSelecMain);
                m_rem = (int'(bus.wCount) > 64) ? 64 : int'(bus.wCount);
`ifdef CLEAR_ON_START_EN
                if (m_org) for (int i = 0; i < 64; i++) m_bank[i] = 4'h0;
                else       for (int i = 0; i < 16; i++) m_main[i] = 4'h0;
`endif
                m_mode = (m_rem == 0) ? 2 : 1;
            end
            1: if (bus.rValid) begin
                if (m_org) m_bank[m_idx] = bus.r;
                else       m_main[m_idx] = bus.r;
                m_idx = (m_idx + 1) % (m_org ? 64 : 16);
                m_rem = m_rem - 1;
                if (m_rem == 0) m_mode = 2;
            end
            default: m_mode = 0;
        endcase
    endtask

    // Compare DUT to the model mid-cycle, then advance the model across the next rising edge.
    initial begin
        m_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) m_reset();
            check("rReady", bus.rReady, m_mode == 1);
            check("wBusy", bus.wBusy, m_mode != 0);
            check("wDone", bus.wDone, m_mode == 2);
            check("wData", bus.wData, pack_main());
            check("wDataRegs", bus.wDataRegs, pack_bank());
            if (bus.rValid && bus.rReady) dut_xfers++;
            if (bus.wDone) done_pulses++;
            if (rst_n) m_step();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_xfer(input logic org, input int idx, input int cnt);
        tick();
        bus.wStart = 1'b1;
        bus.wSelecOrigin = org;
        bus.wSelecMain = idx[3:0];
        bus.wSelecRegs = idx[5:0];
        bus.wCount = cnt[6:0];
        tick();
        bus.wStart = 1'b0;
    endtask

    // mode 0: rValid always, 1: alternating, 2: random; stop_after >= 0 leaves mid-transfer.
    task automatic stream(input int mode, input int stop_after, input bit poke_start);
        int pos = 0;
        bit v;
        bit finished = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (bus.wDone || (stop_after >= 0 && pos == stop_after)) begin
                finished = 1'b1;
                break;
            end
            case (mode)
                0: v = 1'b1;
                1: v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (poke_start && c == 1) begin
                bus.wStart = 1'b1;
                bus.wSelecOrigin = 1'b1;
                bus.wCount = 7'd7;
            end else begin
                bus.wStart = 1'b0;
            end
            bus.rValid = v;
            bus.r = (pos < feed_q.size()) ? feed_q[pos] : 4'h0;
            if (v && bus.rReady) pos++;
            tick();
        end
        bus.rValid = 1'b0;
        bus.wStart = 1'b0;
        if (!finished) begin
            vectors++;
            miscompares++;
            $display("FAIL stream_timeout: got no wDone expected wDone within 400 cycles");
        end
    endtask

    logic [63:0]  snap_main;
    logic [255:0] snap_bank;
    logic [255:0] exp_bank;
    logic [63:0]  exp_main;
    int x0;
    int d0;

    initial begin
        bus.wStart = 1'b0; bus.wSelecOrigin = 1'b0; bus.wSelecMain = 4'd0;
        bus.wSelecRegs = 6'd0; bus.wCount = 7'd0; bus.r = 4'h0; bus.rValid = 1'b0;
        tick(); tick();
        check("rst_rReady", bus.rReady, 1'b0);
        check("rst_wBusy", bus.wBusy, 1'b0);
        check("rst_wDone", bus.wDone, 1'b0);
        check("rst_wData", bus.wData, 64'h0);
        check("rst_wDataRegs", bus.wDataRegs, 256'h0);
        rst_n = 1'b1;

        // Main-word fill with f..0 from index 0.
        feed_q.delete();
        for (int k = 0; k < 16; k++) feed_q.push_back(4'(15 - k));
        x0 = dut_xfers; d0 = done_pulses;
        start_xfer(1'b0, 0, 16);
        stream(0, -1, 1'b0);
        tick();
        check("fill_wData", bus.wData, 64'h0123456789abcdef);
        check("fill_xfers", 32'(dut_xfers - x0), 32'd16);
        check("fill_done_pulses", 32'(done_pulses - d0), 32'd1);

        // Bank wrap 62..1.
        snap_main = bus.wData; snap_bank = bus.wDataRegs;
        feed_q.delete();
        for (int k = 1; k <= 4; k++) feed_q.push_back(4'(k));
        start_xfer(1'b1, 62, 4);
        stream(0, -1, 1'b0);
        tick();
        exp_bank = snap_bank;
`ifdef CLEAR_ON_START_EN
        exp_bank = 256'h0;
`endif
        exp_bank[62*4 +: 4] = 4'h1; exp_bank[63*4 +: 4] = 4'h2;
        exp_bank[3:0] = 4'h3;       exp_bank[7:4] = 4'h4;
        check("wrap_bank", bus.wDataRegs, exp_bank);
        check("wrap_main", bus.wData, snap_main);

        // Backpressure with a start pulse during the transfer.
        snap_main = bus.wData; snap_bank = bus.wDataRegs;
        feed_q.delete();
        feed_q.push_back(4'ha); feed_q.push_back(4'hb); feed_q.push_back(4'hc);
        x0 = dut_xfers;
        start_xfer(1'b0, 5, 3);
        stream(1, -1, 1'b1);
        tick();
        exp_main = snap_main;
`ifdef CLEAR_ON_START_EN
        exp_main = 64'h0;
`endif
        exp_main[23:20] = 4'ha; exp_main[27:24] = 4'hb; exp_main[31:28] = 4'hc;
        check("bp_xfers", 32'(dut_xfers - x0), 32'd3);
        check("bp_main", bus.wData, exp_main);
        check("bp_bank", bus.wDataRegs, snap_bank);

        // Count zero: done one cycle after start, no writes.
        snap_main = bus.wData; snap_bank = bus.wDataRegs;
        x0 = dut_xfers;
        start_xfer(1'b0, 3, 0);
        check("cnt0_done", bus.wDone, 1'b1);
        stream(0, -1, 1'b0);
        tick();
        check("cnt0_xfers", 32'(dut_xfers - x0), 32'd0);
`ifdef CLEAR_ON_START_EN
        check("cnt0_main", bus.wData, 64'h0);
`else
        check("cnt0_main", bus.wData, snap_main);
`endif
        check("cnt0_bank", bus.wDataRegs, snap_bank);

        // Count 100 saturates to 64 nibbles around the bank.
        feed_q.delete();
        for (int k = 0; k < 80; k++) feed_q.push_back(4'($urandom_range(0, 15)));
        x0 = dut_xfers;
        start_xfer(1'b1, 5, 100);
        stream(0, -1, 1'b0);
        tick();
        for (int k = 0; k < 64; k++) exp_bank[((5 + k) % 64)*4 +: 4] = feed_q[k];
        check("sat_xfers", 32'(dut_xfers - x0), 32'd64);
        check("sat_bank", bus.wDataRegs, exp_bank);

        // Randomized transfers against the model.
        for (int t = 0; t < 15; t++) begin
            feed_q.delete();
            for (int k = 0; k < 80; k++) feed_q.push_back(4'($urandom_range(0, 15)));
            start_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 80)));
            stream(2, -1, 1'b0);
            tick();
        end

        // Asynchronous reset after 2 of 5 nibbles.
        feed_q.delete();
        for (int k = 0; k < 5; k++) feed_q.push_back(4'(k + 6));
        start_xfer(1'b0, 2, 5);
        stream(0, 2, 1'b0);
        d0 = done_pulses;
        rst_n = 1'b0;
        #1;
        check("arst_rReady", bus.rReady, 1'b0);
        check("arst_wBusy", bus.wBusy, 1'b0);
        check("arst_wData", bus.wData, 64'h0);
        check("arst_wDataRegs", bus.wDataRegs, 256'h0);
        tick(); tick();
        check("arst_no_done", 32'(done_pulses - d0), 32'd0);
        rst_n = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
